risc_eunit_pipe: RTL and testbench
==================================

Name: risc_eunit_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit execution unit.
- Contains a REG_N x DATA_W register file, a 2-stage read/execute pipeline with result forwarding, valid/ready handshakes on issue and result, and a status-flag register.
- Sits between the instruction decoder (issue side) and the writeback/observation logic (result side).
- An external preload port initialises registers.

Parameters:
DATA_W, 8, operand/result/register width (>=4)
ADDR_W, 3, register address width; REG_N = 2**ADDR_W registers

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  issue request
in_ready  out  1  unit accepts issue this cycle
opcode  in  4  operation code
opnda_addr  in  ADDR_W  source A register
opndb_addr  in  ADDR_W  source B register
dest_addr  in  ADDR_W  destination register
ext_we  in  1  external register write enable
ext_waddr  in  ADDR_W  external write address
ext_wdata  in  DATA_W  external write data
rslt  out  DATA_W  registered result
rslt_valid  out  1  rslt holds a new result
rslt_ready  in  1  consumer accepts result
flags  out  4  {v,c,n,z}, registered with rslt

Behaviour:
- Reset (one clk edge with rst=1): all registers = 0; rslt = 0; rslt_valid = 0; flags = 0; stage-1 valid = 0; in_ready = 1 on the following cycle. Reset aborts any in-flight op; no register write occurs.
- Issue: an op is accepted at an edge where in_valid && in_ready. Stage 1 captures opcode, dest_addr and both operands at that edge.
- Execute: at the next edge, stage 2 registers rslt, flags, rslt_valid=1 and writes regfile[dest_addr]=rslt.
- Latency: 2 edges from accept to rslt visible. Throughput: 1 op/cycle.
- Stall: when rslt_valid && !rslt_ready, stage 2 holds rslt and flags, stage 1 holds, and in_ready = 0 if stage 1 is occupied. A result is consumed at an edge where rslt_valid && rslt_ready; rslt_valid clears unless a new result loads at the same edge.
- Forwarding: an operand whose address equals stage-1 dest_addr (stage-1 valid, writing op) takes the ALU output combinationally, never the stale register. Both operands are forwarded independently.
- Opcodes (a = A, b = B, arithmetic mod 2**DATA_W):
  - 0000 nop: no result, no write, flags hold.
  - 0001 add a+b; 0010 sub a-b; 0011 and; 0100 or; 0101 xor.
  - 0110 inc a+1; 0111 dec a-1; 1000 not ~a; 1001 neg -a.
  - 1010 shr (logical, right); 1011 shl; 1100 ror by 1; 1101 rol by 1.
  - 1110 reserved: behaves as nop.
  - 1111 st: rslt = a, written to dest.
- Flags on every result:
  - z = (rslt==0); n = rslt[DATA_W-1].
  - c: add/inc carry-out; sub/dec/neg borrow; shifts/rotates = bit shifted out; all others 0.
  - v: signed overflow for add/sub/inc/dec/neg; 0 otherwise.
- ext write: applied at the edge when ext_we=1. Not forwarded: a same-cycle read returns the old value. On a same-edge, same-address collision with pipeline writeback, the pipeline value wins.
- dest_addr may equal a source address; the read happens before the write.

Optional Feature:
- EUNIT_MUL_EN defined: opcode 1110 = mul. rslt = low DATA_W bits of unsigned a*b; c = OR of the high DATA_W bits; v = 0; latency unchanged.
- Undefined: 1110 is nop, and no multiplier is synthesised.

Test Plan:
- Preload via ext_we: r0..r7 = 00,22,44,66,88,aa,cc,ff; issue add r0,r7 -> r0 => 2 edges later rslt=ff, flags z0 n1 c0 v0, r0=ff.
- sub r1,r6 -> r1 (22-cc) => rslt=56, c=1; then rol r3 (66) => rslt=cc, c=0; then ror of ee => rslt=77, c=0.
- Forwarding: back-to-back add r1=r1+r2 (22+44) then xor r4=r1^r3 => second rslt=00, z=1; no stale 22 used.
- Backpressure: rslt_ready=0 for 3 cycles with 2 ops issued => rslt/flags hold, in_ready=0 after stage 1 fills; on release, results arrive in order with none lost.
- Reset mid-op: assert rst one cycle after an issue => rslt_valid=0, rslt=00, flags=0, dest register reads 00.
- inc ff => 00, z1 c1; neg 01 => ff, c1; opcode 1110 => no rslt_valid without EUNIT_MUL_EN; with it, mul 10*10 => 00, c=1.

Source files
------------

// File: rtl/risc_eunit_pipe_if.sv
// Issue, result and external-preload signals of the pipelined execution unit.
// The unit itself connects through the slave modport; whoever drives issue uses master.
interface risc_eunit_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] opnda_addr;
  logic [ADDR_W-1:0] opndb_addr;
  logic [ADDR_W-1:0] dest_addr;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_waddr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] rslt;
  logic              rslt_valid;
  logic              rslt_ready;
  logic [3:0]        flags;

  modport master (
    output in_valid, opcode, opnda_addr, opndb_addr, dest_addr,
    output ext_we, ext_waddr, ext_wdata, rslt_ready,
    input  in_ready, rslt, rslt_valid, flags
  );

  modport slave (
    input  in_valid, opcode, opnda_addr, opndb_addr, dest_addr,
    input  ext_we, ext_waddr, ext_wdata, rslt_ready,
    output in_ready, rslt, rslt_valid, flags
  );
endinterface

// File: rtl/risc_eunit_pipe.sv
// Two-stage pipelined execution unit: register file, operand read with forwarding, ALU, flagged result.
// Define EUNIT_MUL_EN to turn opcode 1110 into an unsigned multiply; otherwise 1110 is a nop.
module risc_eunit_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic               clk,
  input logic               rst,
  risc_eunit_pipe_if.slave  bus
);
  localparam int REG_N = 2 ** ADDR_W;
  localparam int MSB   = DATA_W - 1;

`ifdef EUNIT_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_XOR = 4'h5, OP_INC = 4'h6, OP_DEC = 4'h7,
    OP_NOT = 4'h8, OP_NEG = 4'h9, OP_SHR = 4'ha, OP_SHL = 4'hb,
    OP_ROR = 4'hc, OP_ROL = 4'hd, OP_MUL = 4'he, OP_ST  = 4'hf
  } op_e;

  logic [DATA_W-1:0] regs [REG_N];

  logic              s1_valid;
  op_e               s1_op;
  logic [ADDR_W-1:0] s1_dest;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic              s1_writes;

  logic [DATA_W-1:0] rslt_q;
  logic [3:0]        flags_q;
  logic              rslt_valid_q;

  logic [DATA_W-1:0] alu_r;
  logic              alu_c;
  logic              alu_v;
  logic [DATA_W:0]   wide;

  logic              s2_free;
  logic              in_ready;
  logic              wb;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  assign s1_writes = (s1_op != OP_NOP) && ((s1_op != OP_MUL) || MUL_EN);
  assign s2_free   = !rslt_valid_q || bus.rslt_ready;
  assign in_ready  = !s1_valid || s2_free;
  assign wb        = s1_valid && s2_free && s1_writes;

  assign bus.in_ready   = in_ready;
  assign bus.rslt       = rslt_q;
  assign bus.flags      = flags_q;
  assign bus.rslt_valid = rslt_valid_q;

`ifdef EUNIT_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = s1_a * s1_b;
`endif

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    wide  = '0;
    case (s1_op)
      OP_ADD: begin
        wide  = {1'b0, s1_a} + {1'b0, s1_b};
        alu_r = wide[MSB:0];
        alu_c = wide[DATA_W];
        alu_v = (s1_a[MSB] == s1_b[MSB]) && (alu_r[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        wide  = {1'b0, s1_a} - {1'b0, s1_b};
        alu_r = wide[MSB:0];
        alu_c = wide[DATA_W];
        alu_v = (s1_a[MSB] != s1_b[MSB]) && (alu_r[MSB] != s1_a[MSB]);
      end
      OP_AND: alu_r = s1_a & s1_b;
      OP_OR:  alu_r = s1_a | s1_b;
      OP_XOR: alu_r = s1_a ^ s1_b;
      OP_INC: begin
        wide  = {1'b0, s1_a} + (DATA_W+1)'(1);
        alu_r = wide[MSB:0];
        alu_c = wide[DATA_W];
        alu_v = !s1_a[MSB] && alu_r[MSB];
      end
      OP_DEC: begin
        wide  = {1'b0, s1_a} - (DATA_W+1)'(1);
        alu_r = wide[MSB:0];
        alu_c = wide[DATA_W];
        alu_v = s1_a[MSB] && !alu_r[MSB];
      end
      OP_NOT: alu_r = ~s1_a;
      // Negating the most negative value is the only overflow case.
      OP_NEG: begin
        wide  = {(DATA_W+1){1'b0}} - {1'b0, s1_a};
        alu_r = wide[MSB:0];
        alu_c = wide[DATA_W];
        alu_v = s1_a[MSB] && alu_r[MSB];
      end
      OP_SHR: begin
        alu_r = {1'b0, s1_a[MSB:1]};
        alu_c = s1_a[0];
      end
      OP_SHL: begin
        alu_r = {s1_a[MSB-1:0], 1'b0};
        alu_c = s1_a[MSB];
      end
      OP_ROR: begin
        alu_r = {s1_a[0], s1_a[MSB:1]};
        alu_c = s1_a[0];
      end
      OP_ROL: begin
        alu_r = {s1_a[MSB-1:0], s1_a[MSB]};
        alu_c = s1_a[MSB];
      end
`ifdef EUNIT_MUL_EN
      OP_MUL: begin
        alu_r = prod[MSB:0];
        alu_c = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      OP_ST:  alu_r = s1_a;
      default: ;
    endcase
  end

  // The op in stage 1 has not been written back yet, so its ALU output overrides the register.
  always_comb begin
    opnd_a = regs[bus.opnda_addr];
    opnd_b = regs[bus.opndb_addr];
    if (s1_valid && s1_writes && (s1_dest == bus.opnda_addr)) opnd_a = alu_r;
    if (s1_valid && s1_writes && (s1_dest == bus.opndb_addr)) opnd_b = alu_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_NOP;
      s1_dest  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op   <= op_e'(bus.opcode);
        s1_dest <= bus.dest_addr;
        s1_a    <= opnd_a;
        s1_b    <= opnd_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rslt_q       <= '0;
      flags_q      <= '0;
      rslt_valid_q <= 1'b0;
    end else if (wb) begin
      rslt_q       <= alu_r;
      flags_q      <= {alu_v, alu_c, alu_r[MSB], (alu_r == '0)};
      rslt_valid_q <= 1'b1;
    end else if (bus.rslt_ready) begin
      rslt_valid_q <= 1'b0;
    end
  end

  // Pipeline writeback is assigned last so it wins a same-address collision with the preload port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else begin
      if (bus.ext_we) regs[bus.ext_waddr] <= bus.ext_wdata;
      if (wb) regs[s1_dest] <= alu_r;
    end
  end
endmodule

// File: tb/tb_risc_eunit_pipe.sv
// Directed testbench for risc_eunit_pipe: a sequential reference model predicts every result,
// and hand-computed literals pin both the model and the key scenarios.
module tb_risc_eunit_pipe;
  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int MOD = 1 << DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int          model_regs [8];
  int          exp_r [$];
  logic [3:0]  exp_f [$];

  risc_eunit_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  risc_eunit_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int sgn(input int x);
    return (x >= MOD / 2) ? x - MOD : x;
  endfunction

  function automatic bit ovf(input int x);
    return (x >= MOD / 2) || (x < -(MOD / 2));
  endfunction

  // Reference semantics written straight from the opcode table with integer arithmetic.
  function automatic void model_exec(input int op, input int a, input int b,
                                     output bit wr, output int r, output logic [3:0] f);
    int s;
    bit c;
    bit v;
    s = 0; c = 0; v = 0; wr = 1;
    case (op)
      0:  wr = 0;
      1:  begin s = a + b; c = (s >= MOD); v = ovf(sgn(a) + sgn(b)); end
      2:  begin s = a - b; c = (s < 0);    v = ovf(sgn(a) - sgn(b)); end
      3:  s = a & b;
      4:  s = a | b;
      5:  s = a ^ b;
      6:  begin s = a + 1; c = (s >= MOD); v = ovf(sgn(a) + 1); end
      7:  begin s = a - 1; c = (s < 0);    v = ovf(sgn(a) - 1); end
      8:  s = MOD - 1 - a;
      9:  begin s = 0 - a; c = (s < 0);    v = ovf(-sgn(a)); end
      10: begin s = a / 2; c = (a % 2 == 1); end
      11: begin s = a * 2; c = (s >= MOD); end
      12: begin s = a / 2 + (a % 2) * (MOD / 2); c = (a % 2 == 1); end
      13: begin s = (a * 2) % MOD + a / (MOD / 2); c = (a >= MOD / 2); end
`ifdef EUNIT_MUL_EN
      14: begin s = a * b; c = (s >= MOD); end
`else
      14: wr = 0;
`endif
      default: s = a;
    endcase
    r = ((s % MOD) + MOD) % MOD;
    f = {v, c, (r >= MOD / 2), (r == 0)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Compare process: outputs are stable at the falling edge; accepted issues are modelled in program order.
  always @(negedge clk) begin : cmp
    bit         wr;
    int         r;
    logic [3:0] f;
    if (rst) begin
      exp_r.delete();
      exp_f.delete();
      foreach (model_regs[i]) model_regs[i] = 0;
    end else begin
      if (bus.rslt_valid === 1'b1) begin
        if (exp_r.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          checkOutput("model_rslt", bus.rslt, exp_r[0]);
          checkOutput("model_flags", bus.flags, exp_f[0]);
          if (bus.rslt_ready) begin
            void'(exp_r.pop_front());
            void'(exp_f.pop_front());
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        model_exec(int'(bus.opcode), model_regs[bus.opnda_addr], model_regs[bus.opndb_addr], wr, r, f);
        if (wr) begin
          model_regs[bus.dest_addr] = r;
          exp_r.push_back(r);
          exp_f.push_back(f);
        end
      end
      if (bus.ext_we) model_regs[bus.ext_waddr] = int'(bus.ext_wdata);
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic applyStimulus(input logic [3:0] op, input int a, input int b, input int d);
    bit ok;
    ok = 0;
    bus.in_valid   = 1'b1;
    bus.opcode     = op;
    bus.opnda_addr = AW'(a);
    bus.opndb_addr = AW'(b);
    bus.dest_addr  = AW'(d);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("issue_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic extWrite(input int a, input int d);
    bus.ext_we    = 1'b1;
    bus.ext_waddr = AW'(a);
    bus.ext_wdata = DW'(d);
    @(posedge clk);
    #1;
    bus.ext_we = 1'b0;
  endtask

  // Ends at a falling edge so consecutive results can be collected back to back.
  task automatic waitResult(input int r, input logic [3:0] f, input string name);
    bit found;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rslt_valid === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checkOutput({name, "_timeout"}, 0, 1);
    end else begin
      checkOutput({name, "_rslt"}, bus.rslt, r);
      checkOutput({name, "_flags"}, bus.flags, f);
    end
  endtask

  task automatic syncPhase();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit         wr;
    int         r;
    logic [3:0] f;
    int         seen;
    logic [3:0] held;
    int         tbl [6][4] = '{
      '{10, 3, 3, 4}, '{11, 4, 4, 4}, '{7, 1, 1, 1},
      '{2, 2, 0, 7},  '{0, 0, 0, 0},  '{8, 7, 7, 7}
    };

    bus.in_valid = 0; bus.opcode = 0; bus.opnda_addr = 0; bus.opndb_addr = 0; bus.dest_addr = 0;
    bus.ext_we = 0; bus.ext_waddr = 0; bus.ext_wdata = 0; bus.rslt_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rslt_valid", bus.rslt_valid, 0);
    checkOutput("reset_rslt", bus.rslt, 0);
    checkOutput("reset_flags", bus.flags, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);
    syncPhase();

    model_exec(2, 'h22, 'hcc, wr, r, f);
    checkOutput("model_pin_sub", {f, r[7:0]}, 12'h456);
    model_exec(13, 'h66, 0, wr, r, f);
    checkOutput("model_pin_rol", {f, r[7:0]}, 12'h2cc);
    model_exec(9, 'h01, 0, wr, r, f);
    checkOutput("model_pin_neg", {f, r[7:0]}, 12'h6ff);
    model_exec(6, 'hff, 0, wr, r, f);
    checkOutput("model_pin_inc", {f, r[7:0]}, 12'h500);

    extWrite(0, 'h00); extWrite(1, 'h22); extWrite(2, 'h44); extWrite(3, 'h66);
    extWrite(4, 'h88); extWrite(5, 'haa); extWrite(6, 'hcc); extWrite(7, 'hff);

    applyStimulus(4'h1, 0, 7, 0);
    @(negedge clk);
    checkOutput("latency_not_early", bus.rslt_valid, 0);
    waitResult('hff, 4'b0010, "add");
    syncPhase();
    applyStimulus(4'h2, 1, 6, 1);
    waitResult('h56, 4'b0100, "sub");
    syncPhase();
    applyStimulus(4'hd, 3, 3, 3);
    waitResult('hcc, 4'b0010, "rol");
    syncPhase();
    extWrite(5, 'hee);
    applyStimulus(4'hc, 5, 5, 5);
    waitResult('h77, 4'b0000, "ror");
    syncPhase();

    extWrite(1, 'h22); extWrite(3, 'h66);
    applyStimulus(4'h1, 1, 2, 1);
    applyStimulus(4'h5, 1, 3, 4);
    waitResult('h66, 4'b0000, "fwd_add");
    waitResult('h00, 4'b0001, "fwd_xor");
    syncPhase();
    applyStimulus(4'h1, 2, 2, 2);
    applyStimulus(4'h2, 2, 2, 6);
    waitResult('h88, 4'b1010, "fwd_add_ovf");
    waitResult('h00, 4'b0001, "fwd_both_sub");
    syncPhase();

    bus.rslt_ready = 1'b0;
    applyStimulus(4'h1, 1, 3, 5);
    applyStimulus(4'h5, 0, 1, 6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", bus.in_ready, 0);
      checkOutput("stall_rslt", bus.rslt, 'hcc);
      checkOutput("stall_flags", bus.flags, 4'b1010);
    end
    syncPhase();
    bus.rslt_ready = 1'b1;
    waitResult('hcc, 4'b1010, "bp_first");
    waitResult('h99, 4'b0010, "bp_second");
    syncPhase();

    applyStimulus(4'h1, 1, 2, 3);
    rst = 1'b1;
    syncPhase();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rslt_valid", bus.rslt_valid, 0);
    checkOutput("midrst_rslt", bus.rslt, 0);
    checkOutput("midrst_flags", bus.flags, 0);
    syncPhase();
    applyStimulus(4'hf, 3, 0, 3);
    waitResult('h00, 4'b0001, "midrst_dest_zero");
    syncPhase();

    extWrite(0, 'hff);
    applyStimulus(4'h6, 0, 0, 1);
    waitResult('h00, 4'b0101, "inc_wrap");
    syncPhase();
    extWrite(2, 'h01);
    applyStimulus(4'h9, 2, 2, 3);
    waitResult('hff, 4'b0110, "neg_one");
    syncPhase();

    held = bus.flags;
    extWrite(4, 'h10);
    applyStimulus(4'he, 4, 4, 5);
`ifdef EUNIT_MUL_EN
    waitResult('h00, 4'b0101, "mul");
    syncPhase();
`else
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.rslt_valid === 1'b1) seen++;
    end
    checkOutput("rsv_no_result", seen, 0);
    checkOutput("rsv_flags_hold", bus.flags, held);
    syncPhase();
`endif

    foreach (tbl[i]) applyStimulus(4'(tbl[i][0]), tbl[i][1], tbl[i][2], tbl[i][3]);
    repeat (6) syncPhase();
    checkOutput("queue_drained", exp_r.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
